// File: rtl/avalon_pio_gen.sv
// avalon_pio_gen: Avalon-MM general-purpose I/O port with direction control, set/clear and edge capture.
// Define AVALON_PIO_GEN_IRQ_EN to build the edge-capture and interrupt logic; otherwise irq is tied low.
module avalon_pio_gen #(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'd0,
    parameter int          EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] data_rd;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign rd_en        = chipselect & read;
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= RESET_VALUE[WIDTH-1:0];
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:   data_out <= wdata;
                ADDR_OUTSET: data_out <= data_out | wdata;
                ADDR_OUTCLR: data_out <= data_out & ~wdata;
                default:     data_out <= data_out;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir <= '0;
        end else if (wr_en && address == ADDR_DIR) begin
            dir <= wdata;
        end
    end

    // Two-flop synchroniser for the asynchronous pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= in_port;
            s2 <= s1;
        end
    end

    assign out_port = data_out;
    assign oe       = dir;
    assign data_rd  = (dir & data_out) | (~dir & s2);

`ifdef AVALON_PIO_GEN_IRQ_EN
    logic [WIDTH-1:0] s3;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] w1c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s3 <= '0;
        end else begin
            s3 <= s2;
        end
    end

    always_comb begin
        edge_det = '0;
        if (EDGE_TYPE == 0) begin
            edge_det = s2 & ~s3;
        end else if (EDGE_TYPE == 1) begin
            edge_det = ~s2 & s3;
        end else begin
            edge_det = s2 ^ s3;
        end
    end

    assign w1c = (wr_en && address == ADDR_EDGECAP) ? wdata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_mask <= '0;
        end else if (wr_en && address == ADDR_IRQMASK) begin
            irq_mask <= wdata;
        end
    end

    // A new edge wins over a clear landing on the same bit in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_cap <= '0;
        end else begin
            edge_cap <= (edge_cap & ~w1c) | edge_det;
        end
    end

    assign irq = |(edge_cap & irq_mask);
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:    rd_mux[WIDTH-1:0] = data_rd;
            ADDR_DIR:     rd_mux[WIDTH-1:0] = dir;
`ifdef AVALON_PIO_GEN_IRQ_EN
            ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irq_mask;
            ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edge_cap;
`endif
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else if (rd_en) begin
            readdata <= rd_mux;
        end else begin
            readdata <= '0;
        end
    end

endmodule

// File: tb/tb_avalon_pio_gen.sv
// tb_avalon_pio_gen: directed register, pin and interrupt tests for avalon_pio_gen (WIDTH=8, RESET_VALUE=0x3C).
// Interrupt scenarios follow the AVALON_PIO_GEN_IRQ_EN build setting.
module tb_avalon_pio_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        read = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  in_port = '0;
    logic [7:0]  out_port;
    logic [7:0]  oe;
    logic        irq;

    int errors = 0;
    int checks = 0;

    avalon_pio_gen #(
        .WIDTH      (8),
        .RESET_VALUE(32'h3C),
        .EDGE_TYPE  (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .read      (read),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .out_port  (out_port),
        .oe        (oe),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = a;
        @(negedge clk);
        chipselect = 1'b0;
        read       = 1'b0;
        d = readdata;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if (out_port !== 8'h3C) begin errors++; $display("FAIL reset_out_port: got %h expected 3c", out_port); end
        checks++; if (oe !== 8'h00) begin errors++; $display("FAIL reset_oe: got %h expected 00", oe); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h expected 0", readdata); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_data_rw;
        logic [31:0] rd;
        bus_write(3'd0, 32'h1A5);
        checks++; if (out_port !== 8'hA5) begin errors++; $display("FAIL data_write: got %h expected a5", out_port); end
        bus_write(3'd1, 32'hFF);
        checks++; if (oe !== 8'hFF) begin errors++; $display("FAIL dir_oe: got %h expected ff", oe); end
        bus_read(3'd0, rd);
        checks++; if (rd !== 32'h000000A5) begin errors++; $display("FAIL data_read: got %h expected 000000a5", rd); end
        @(negedge clk);
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL readdata_idle: got %h expected 0", readdata); end
        bus_read(3'd1, rd);
        checks++; if (rd !== 32'h000000FF) begin errors++; $display("FAIL dir_read: got %h expected 000000ff", rd); end
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b0; address = 3'd0; writedata = 32'h11;
        @(negedge clk);
        write_n = 1'b1; writedata = '0;
        checks++; if (out_port !== 8'hA5) begin errors++; $display("FAIL write_no_cs: got %h expected a5", out_port); end
        @(negedge clk);
        read = 1'b1; address = 3'd0;
        @(negedge clk);
        read = 1'b0;
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL read_no_cs: got %h expected 0", readdata); end
    endtask

    task automatic test_set_clr;
        logic [31:0] rd;
        bus_write(3'd4, 32'h0A);
        checks++; if (out_port !== 8'hAF) begin errors++; $display("FAIL outset: got %h expected af", out_port); end
        bus_write(3'd5, 32'h81);
        checks++; if (out_port !== 8'h2E) begin errors++; $display("FAIL outclr: got %h expected 2e", out_port); end
        bus_read(3'd4, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL outset_read: got %h expected 0", rd); end
        bus_read(3'd5, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL outclr_read: got %h expected 0", rd); end
        bus_read(3'd6, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL addr6_read: got %h expected 0", rd); end
        bus_write(3'd6, 32'h77);
        bus_write(3'd7, 32'h77);
        checks++; if (out_port !== 8'h2E || oe !== 8'hFF) begin
            errors++; $display("FAIL unmapped_write: got out=%h oe=%h expected out=2e oe=ff", out_port, oe);
        end
    endtask

    task automatic test_mixed_read;
        logic [31:0] rd;
        bus_write(3'd1, 32'h0F);
        bus_write(3'd0, 32'h03);
        @(negedge clk);
        in_port = 8'hC0;
        repeat (3) @(negedge clk);
        bus_read(3'd0, rd);
        checks++; if (rd !== 32'h000000C3) begin errors++; $display("FAIL mixed_read: got %h expected 000000c3", rd); end
    endtask

`ifdef AVALON_PIO_GEN_IRQ_EN
    task automatic test_irq;
        logic [31:0] rd;
        bus_read(3'd3, rd);
        checks++; if (rd !== 32'h000000C0) begin errors++; $display("FAIL edgecap_c0: got %h expected 000000c0", rd); end
        bus_write(3'd3, 32'hFF);
        bus_read(3'd3, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL edgecap_clear: got %h expected 0", rd); end
        bus_write(3'd2, 32'h01);
        bus_read(3'd2, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL irqmask_read: got %h expected 1", rd); end
        @(negedge clk);
        in_port = 8'hC1;
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_k: got %b expected 0", irq); end
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_k1: got %b expected 0", irq); end
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_k2: got %b expected 1", irq); end
        bus_write(3'd3, 32'h01);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_w1c: got %b expected 0", irq); end
        in_port = 8'hC0;
        repeat (3) @(negedge clk);
        in_port = 8'hC1;
        repeat (3) @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_second_edge: got %b expected 1", irq); end
        in_port = 8'hC0;
        repeat (3) @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_fall_ignored: got %b expected 1", irq); end
        @(negedge clk);
        in_port = 8'hC1;
        @(negedge clk);
        bus_write(3'd3, 32'h01);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set_priority: got %b expected 1", irq); end
        bus_read(3'd3, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL edgecap_priority: got %h expected 1", rd); end
        bus_write(3'd3, 32'h01);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_final_clear: got %b expected 0", irq); end
    endtask
`else
    task automatic test_irq;
        logic [31:0] rd;
        bus_write(3'd2, 32'hFF);
        bus_write(3'd3, 32'hFF);
        @(negedge clk);
        in_port = 8'hC1;
        repeat (4) @(negedge clk);
        bus_read(3'd2, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL irqmask_absent: got %h expected 0", rd); end
        bus_read(3'd3, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL edgecap_absent: got %h expected 0", rd); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_tied: got %b expected 0", irq); end
    endtask
`endif

    task automatic test_reset_mid_run;
        logic [31:0] rd;
        bus_write(3'd0, 32'h55);
        bus_write(3'd1, 32'hFF);
`ifdef AVALON_PIO_GEN_IRQ_EN
        bus_write(3'd2, 32'h01);
        in_port = 8'h00;
        repeat (3) @(negedge clk);
        in_port = 8'h01;
        repeat (3) @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_before_reset: got %b expected 1", irq); end
`endif
        bus_read(3'd0, rd);
        checks++; if (rd !== 32'h55) begin errors++; $display("FAIL data_before_reset: got %h expected 55", rd); end
        #2 reset = 1'b1;
        #1;
        checks++; if (out_port !== 8'h3C) begin errors++; $display("FAIL async_out_port: got %h expected 3c", out_port); end
        checks++; if (oe !== 8'h00) begin errors++; $display("FAIL async_oe: got %h expected 00", oe); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL async_irq: got %b expected 0", irq); end
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL async_readdata: got %h expected 0", readdata); end
        in_port = 8'h01;
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = 3'd0; writedata = 32'hFF;
        repeat (2) @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        checks++; if (out_port !== 8'h3C) begin errors++; $display("FAIL write_in_reset: got %h expected 3c", out_port); end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        bus_read(3'd0, rd);
        checks++; if (rd !== 32'h01) begin errors++; $display("FAIL pin_after_reset: got %h expected 1", rd); end
        bus_read(3'd3, rd);
`ifdef AVALON_PIO_GEN_IRQ_EN
        checks++; if (rd !== 32'h01) begin errors++; $display("FAIL release_edge: got %h expected 1", rd); end
`else
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL release_edge: got %h expected 0", rd); end
`endif
    endtask

    initial begin
        test_reset();
        test_data_rw();
        test_set_clr();
        test_mixed_read();
        test_irq();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
